// File: rtl/reorder_buffer_pkg.sv
// Shared widths, issue-type codes and the ROB entry layout used by the
// reorder buffer and its bus interface.
package reorder_buffer_pkg;

    localparam int ROB_SIZE    = 16;
    localparam int ROB_POS_WID = 4;
    localparam int ROB_ID_WID  = 5;
    localparam int DATA_WID    = 32;
    localparam int REG_POS_WID = 5;

    typedef enum logic [1:0] {
        TYPE_REG    = 2'd0,
        TYPE_STORE  = 2'd1,
        TYPE_BRANCH = 2'd2,
        TYPE_EXIT   = 2'd3
    } rob_type_e;

    typedef struct packed {
        logic                   busy;
        logic                   ready;
        rob_type_e              rtype;
        logic [REG_POS_WID-1:0] rd;
        logic [DATA_WID-1:0]    val;
        logic [DATA_WID-1:0]    pc;
        logic                   pred_jump;
        logic                   jump;
        logic [DATA_WID-1:0]    target;
    } rob_entry_t;

    // A resolved branch whose outcome disagrees with the fetch-time prediction
    function automatic logic is_mispredict(input rob_entry_t e);
        return (e.rtype == TYPE_BRANCH) && (e.jump != e.pred_jump);
    endfunction

endpackage

// File: rtl/reorder_buffer_if.sv
// Bus bundle between the reorder buffer and the rest of the core: issue,
// result broadcasts, operand queries, commit and rollback.
interface reorder_buffer_if #(
    parameter int ROB_POS_W = reorder_buffer_pkg::ROB_POS_WID
);
    logic                 rdy;
    logic                 issue;
    logic [1:0]           issue_type;
    logic [4:0]           issue_rd;
    logic [31:0]          issue_pc;
    logic                 issue_pred_jump;
    logic                 issue_ready;
    logic [31:0]          issue_val;
    logic                 rob_full;
    logic [ROB_POS_W-1:0] rob_tail;
    logic                 alu_result;
    logic [ROB_POS_W-1:0] alu_rob_pos;
    logic [31:0]          alu_val;
    logic                 alu_jump;
    logic [31:0]          alu_pc;
    logic                 lsb_result;
    logic [ROB_POS_W-1:0] lsb_rob_pos;
    logic [31:0]          lsb_val;
    logic [ROB_POS_W-1:0] q1_pos;
    logic                 q1_ready;
    logic [31:0]          q1_val;
    logic [ROB_POS_W-1:0] q2_pos;
    logic                 q2_ready;
    logic [31:0]          q2_val;
    logic                 commit;
    logic [4:0]           commit_rd;
    logic [31:0]          commit_val;
    logic [ROB_POS_W-1:0] commit_rob_pos;
    logic                 commit_store;
    logic                 rollback;
    logic [31:0]          rollback_pc;
    logic                 halt;

    modport master (
        output rdy, issue, issue_type, issue_rd, issue_pc, issue_pred_jump,
               issue_ready, issue_val, alu_result, alu_rob_pos, alu_val,
               alu_jump, alu_pc, lsb_result, lsb_rob_pos, lsb_val, q1_pos, q2_pos,
        input  rob_full, rob_tail, q1_ready, q1_val, q2_ready, q2_val, commit,
               commit_rd, commit_val, commit_rob_pos, commit_store, rollback,
               rollback_pc, halt
    );

    modport slave (
        input  rdy, issue, issue_type, issue_rd, issue_pc, issue_pred_jump,
               issue_ready, issue_val, alu_result, alu_rob_pos, alu_val,
               alu_jump, alu_pc, lsb_result, lsb_rob_pos, lsb_val, q1_pos, q2_pos,
        output rob_full, rob_tail, q1_ready, q1_val, q2_ready, q2_val, commit,
               commit_rd, commit_val, commit_rob_pos, commit_store, rollback,
               rollback_pc, halt
    );
endinterface

// File: rtl/reorder_buffer.sv
// Circular in-order retirement buffer: allocates slots at the tail, collects
// ALU/LSB results, retires one entry per cycle from the head, owns rollback.
module reorder_buffer #(
    parameter int ROB_SIZE  = reorder_buffer_pkg::ROB_SIZE,
    parameter int ROB_POS_W = reorder_buffer_pkg::ROB_POS_WID
) (
    input  logic            clk,
    input  logic            rst,
    reorder_buffer_if.slave bus
);
    import reorder_buffer_pkg::*;

    localparam logic [ROB_POS_W:0]   CNT_ZERO = {(ROB_POS_W+1){1'b0}};
    localparam logic [ROB_POS_W:0]   CNT_ONE  = {{ROB_POS_W{1'b0}}, 1'b1};
    localparam logic [ROB_POS_W:0]   CNT_FULL = {1'b1, {ROB_POS_W{1'b0}}};
    localparam logic [ROB_POS_W-1:0] POS_ZERO = {ROB_POS_W{1'b0}};
    localparam logic [ROB_POS_W-1:0] POS_ONE  = {{(ROB_POS_W-1){1'b0}}, 1'b1};

    rob_entry_t             rob_r [ROB_SIZE];
    logic [ROB_POS_W-1:0]   head_r;
    logic [ROB_POS_W-1:0]   tail_r;
    logic [ROB_POS_W:0]     count_r;
    logic                   commit_r;
    logic [4:0]             commit_rd_r;
    logic [31:0]            commit_val_r;
    logic [ROB_POS_W-1:0]   commit_pos_r;
    logic                   commit_store_r;
    logic                   rollback_r;
    logic [31:0]            rollback_pc_r;
    logic                   halt_r;

    logic                   full_s;
    logic                   issue_acc_s;
    logic                   alu_acc_s;
    logic                   lsb_acc_s;
    logic                   retire_s;
    logic                   flush_s;
    logic [ROB_POS_W:0]     count_next_s;

    // Qualify this edge's issue, writebacks and head retirement; anything
    // arriving while rollback is high belongs to a squashed instruction
    always_comb begin
        full_s       = (count_r == CNT_FULL);
        issue_acc_s  = bus.issue && !full_s && !rollback_r;
        alu_acc_s    = bus.alu_result && rob_r[bus.alu_rob_pos].busy && !rollback_r;
        lsb_acc_s    = bus.lsb_result && rob_r[bus.lsb_rob_pos].busy && !rollback_r;
        retire_s     = (count_r != CNT_ZERO) && rob_r[head_r].ready && !halt_r;
        flush_s      = retire_s && is_mispredict(rob_r[head_r]);
        count_next_s = count_r;
        if (issue_acc_s && !retire_s) begin
            count_next_s = count_r + CNT_ONE;
        end else if (!issue_acc_s && retire_s) begin
            count_next_s = count_r - CNT_ONE;
        end else begin
            count_next_s = count_r;
        end
    end

    // Operand query forwarding: ALU broadcast, then LSB broadcast, then stored entry
    always_comb begin
        if (bus.alu_result && (bus.alu_rob_pos == bus.q1_pos)) begin
            bus.q1_ready = 1'b1;
            bus.q1_val   = bus.alu_val;
        end else if (bus.lsb_result && (bus.lsb_rob_pos == bus.q1_pos)) begin
            bus.q1_ready = 1'b1;
            bus.q1_val   = bus.lsb_val;
        end else begin
            bus.q1_ready = rob_r[bus.q1_pos].ready;
            bus.q1_val   = rob_r[bus.q1_pos].val;
        end
        if (bus.alu_result && (bus.alu_rob_pos == bus.q2_pos)) begin
            bus.q2_ready = 1'b1;
            bus.q2_val   = bus.alu_val;
        end else if (bus.lsb_result && (bus.lsb_rob_pos == bus.q2_pos)) begin
            bus.q2_ready = 1'b1;
            bus.q2_val   = bus.lsb_val;
        end else begin
            bus.q2_ready = rob_r[bus.q2_pos].ready;
            bus.q2_val   = rob_r[bus.q2_pos].val;
        end
    end

    assign bus.rob_full       = full_s;
    assign bus.rob_tail       = tail_r;
    assign bus.commit         = commit_r;
    assign bus.commit_rd      = commit_rd_r;
    assign bus.commit_val     = commit_val_r;
    assign bus.commit_rob_pos = commit_pos_r;
    assign bus.commit_store   = commit_store_r;
    assign bus.rollback       = rollback_r;
    assign bus.rollback_pc    = rollback_pc_r;
    assign bus.halt           = halt_r;

    // Entry storage, head/tail/count and the registered commit/rollback pulses
    always_ff @(posedge clk) begin
        if (rst) begin
            head_r         <= POS_ZERO;
            tail_r         <= POS_ZERO;
            count_r        <= CNT_ZERO;
            commit_r       <= 1'b0;
            commit_rd_r    <= 5'd0;
            commit_val_r   <= 32'd0;
            commit_pos_r   <= POS_ZERO;
            commit_store_r <= 1'b0;
            rollback_r     <= 1'b0;
            rollback_pc_r  <= 32'd0;
            halt_r         <= 1'b0;
            for (int i = 0; i < ROB_SIZE; i++) begin
                rob_r[i].busy  <= 1'b0;
                rob_r[i].ready <= 1'b0;
            end
        end else if (bus.rdy) begin
            commit_r       <= retire_s && (rob_r[head_r].rd != 5'd0);
            commit_store_r <= retire_s && (rob_r[head_r].rtype == TYPE_STORE);
            rollback_r     <= flush_s;
            if (retire_s) begin
                commit_rd_r  <= rob_r[head_r].rd;
                commit_val_r <= rob_r[head_r].val;
                commit_pos_r <= head_r;
                if (rob_r[head_r].rtype == TYPE_EXIT) begin
                    halt_r <= 1'b1;
                end
                if (flush_s) begin
                    rollback_pc_r <= rob_r[head_r].target;
                end
            end
            if (flush_s) begin
                head_r  <= POS_ZERO;
                tail_r  <= POS_ZERO;
                count_r <= CNT_ZERO;
                for (int i = 0; i < ROB_SIZE; i++) begin
                    rob_r[i].busy  <= 1'b0;
                    rob_r[i].ready <= 1'b0;
                end
            end else begin
                if (issue_acc_s) begin
                    rob_r[tail_r] <= '{busy: 1'b1, ready: bus.issue_ready,
                                       rtype: rob_type_e'(bus.issue_type),
                                       rd: bus.issue_rd, val: bus.issue_val,
                                       pc: bus.issue_pc, pred_jump: bus.issue_pred_jump,
                                       jump: 1'b0, target: 32'd0};
                    tail_r <= tail_r + POS_ONE;
                end
                if (lsb_acc_s) begin
                    rob_r[bus.lsb_rob_pos].ready <= 1'b1;
                    rob_r[bus.lsb_rob_pos].val   <= bus.lsb_val;
                end
                // ALU is written after LSB so it wins if both name one slot
                if (alu_acc_s) begin
                    rob_r[bus.alu_rob_pos].ready  <= 1'b1;
                    rob_r[bus.alu_rob_pos].val    <= bus.alu_val;
                    rob_r[bus.alu_rob_pos].jump   <= bus.alu_jump;
                    rob_r[bus.alu_rob_pos].target <= bus.alu_pc;
                end
                if (retire_s) begin
                    rob_r[head_r].busy  <= 1'b0;
                    rob_r[head_r].ready <= 1'b0;
                    head_r              <= head_r + POS_ONE;
                end
                count_r <= count_next_s;
            end
        end
    end

endmodule

// File: doc/reorder_buffer.md
Name: reorder_buffer

Overview:
- Circular in-order retirement buffer for the Tomasulo RISC-V core.
- Allocates ROB slots to instructions issued by the Decoder and collects results from the ALU and LSB.
- Retires one instruction per cycle from the head. Drives the RegFile commit interface and the store-commit strobe to the LSB.
- Owns the `rollback` signal on branch mispredict: it is the producer of the commit/rollback protocol that RegFile consumes.

Parameters:
- ROB_SIZE, 16, number of entries; must be a power of two.
- ROB_POS_W, 4, log2(ROB_SIZE); equals the `ROB_POS_WID` width.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- rdy  in  1  global enable; state frozen when 0
- issue  in  1  Decoder allocates the tail slot this cycle
- issue_type  in  2  0=REG, 1=STORE, 2=BRANCH, 3=EXIT
- issue_rd  in  5  destination register; 0 means no write
- issue_pc  in  32  PC of the instruction
- issue_pred_jump  in  1  predicted taken
- issue_ready  in  1  result already known at issue (LUI/AUIPC)
- issue_val  in  32  value used when issue_ready=1
- rob_full  out  1  no free slot
- rob_tail  out  ROB_POS_W  slot the next issue receives
- alu_result  in  1  ALU broadcast valid
- alu_rob_pos  in  ROB_POS_W  ALU broadcast target slot
- alu_val  in  32  ALU result value
- alu_jump  in  1  resolved taken
- alu_pc  in  32  resolved next PC
- lsb_result  in  1  LSB broadcast valid
- lsb_rob_pos  in  ROB_POS_W  LSB broadcast target slot
- lsb_val  in  32  LSB result value
- q1_pos  in  ROB_POS_W  operand query 1 slot
- q1_ready  out  1  operand 1 available
- q1_val  out  32  operand 1 value
- q2_pos  in  ROB_POS_W  operand query 2 slot
- q2_ready  out  1  operand 2 available
- q2_val  out  32  operand 2 value
- commit  out  1  one-cycle retire pulse to RegFile
- commit_rd  out  5  retired destination register
- commit_val  out  32  retired value
- commit_rob_pos  out  ROB_POS_W  retired slot
- commit_store  out  1  one-cycle pulse: LSB may perform the store at commit_rob_pos
- rollback  out  1  one-cycle flush pulse
- rollback_pc  out  32  fetch redirect target
- halt  out  1  sticky; EXIT retired

Behaviour:
- Per-entry state: busy, ready, type, rd, val, pc, pred_jump, jump, target. Control state: head, tail, count (width ROB_POS_W+1).
- Reset:
  - head=tail=count=0, all busy/ready=0.
  - commit, commit_store, rollback, halt = 0.
  - commit_rd=0, commit_val=0, commit_rob_pos=0, rollback_pc=0.
- When rdy=0 nothing changes and pulses hold their value. Reset has priority over rdy.
- rob_full = (count==ROB_SIZE), combinational. rob_tail = tail.
- Issue:
  - Issue while full is ignored.
  - Otherwise entry[tail] is written and tail wraps modulo ROB_SIZE.
  - ready = issue_ready; val = issue_val.
- Writeback:
  - An ALU/LSB broadcast to a busy slot sets ready and val.
  - ALU additionally sets jump and target.
  - Both broadcasting in the same cycle to different slots: both written.
- Retire, evaluated each edge from the registered head entry:
  - Condition: count!=0 and entry[head].ready. Results become committable the edge after they are written; there is no same-edge bypass.
  - On retire: head++ (wrapping), busy=0.
  - commit=1 iff rd!=0, with commit_rd/val/rob_pos from the entry.
  - commit_store=1 iff type==STORE.
  - EXIT sets halt, and no further retirement occurs.
  - All pulses deassert on the next edge unless another retire happens.
- Mispredict: a retiring BRANCH with jump!=pred_jump (JAL/JALR also write rd) sets rollback=1 and rollback_pc=target.
  - The same edge clears head/tail/count and every busy/ready.
  - During the cycle rollback=1, issue and broadcasts are ignored, because they come from squashed instructions.
- Simultaneous issue and retire: count unchanged. Issue when full is blocked even if a retire frees a slot that cycle.
- Operand query, combinational:
  - q_ready = entry.ready, OR a broadcast to that slot this cycle (ALU takes priority over LSB).
  - q_val follows the same choice.
- Mid-operation reset discards all entries and drops any pending pulse at the next edge.

Decomposition:
- Shared package/defines (Mydefine.v): ROB_SIZE, ROB_POS_WID, ROB_ID_WID, DATA_WID, REG_POS_WID, and the issue_type codes TYPE_REG/STORE/BRANCH/EXIT.
- Sub-module: none. The query forwarding mux is local combinational logic.

Test Plan:
- Reset, issue REG rd=5 at pos 0, ALU result val=0x1234 cycle t -> commit=1, commit_rd=5, commit_val=0x1234, commit_rob_pos=0 visible cycle t+2; rob_empty-state count returns to 0.
- Issue 16 instructions -> rob_full=1 and rob_tail=0. A 17th issue is ignored. Retire head -> rob_full=0 next cycle.
- Results arrive out of order (pos 2, then 1, then 0) -> commits in order 0, 1, 2 on consecutive cycles.
- BRANCH pred_jump=0, ALU jump=1, alu_pc=0x200 -> rollback=1, rollback_pc=0x200 for one cycle. count=0 and later entries never commit. A broadcast in the rollback cycle is dropped.
- STORE retire -> commit_store=1, commit=0. REG with rd=0 -> commit=0 but head advances.
- q1_pos=3 with slot 3 not ready and an ALU broadcast to pos 3 val=7 in the same cycle -> q1_ready=1, q1_val=7. Wrap-around: issue/retire 20 items -> tail/head wrap and commit_rob_pos sequence is 0..15,0..3.
